laser_frame_deserializer: RTL and testbench



---
 rtl/laser_frame_deserializer.sv | 158 +++++++++++++++
 tb/tb_laser_frame_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/laser_frame_deserializer.sv
// Oversampling single-lane optical receiver. Recovers one DATA_BITS byte per frame
// (start=1, LSB-first data, stop=0) and flags frames whose stop bit is wrong.
module laser_frame_deserializer #(
  parameter int unsigned OVERSAMPLE = 4,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 laser_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned Half = OVERSAMPLE / 2;
  localparam int unsigned CntW = $clog2(OVERSAMPLE) + 1;
  localparam int unsigned BitW = $clog2(DATA_BITS) + 1;

  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] BitOne  = BitW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   laser_s;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;

  // Two-flop synchronizer; every decision below looks only at laser_s.
  assign laser_s = sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], laser_in};
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != StIdle && !en) begin
      // Disabling mid-frame drops the partial byte silently.
      state_d   = StIdle;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en && laser_s) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end

        StStart: begin
          if (cnt_q == CntMid) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A start bit that is gone by mid-bit was a glitch.
            state_d   = laser_s ? StData : StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        StData: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            // Right-shift so the first (LSB) sample lands in bit 0 after the last one.
            shreg_d = shreg_q >> 1;
            shreg_d[DATA_BITS-1] = laser_s;
            if (bit_idx_q == BitLast) begin
              bit_idx_d = '0;
              state_d   = StStop;
            end else begin
              bit_idx_d = bit_idx_q + BitOne;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (!laser_s) begin
              data_out_d   = shreg_q;
              data_valid_d = 1'b1;
              state_d      = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitIdle;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        StWaitIdle: begin
          // Hold off until the beam drops so a stuck-on line cannot re-trigger.
          if (!laser_s) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d   = StIdle;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_laser_frame_deserializer.sv
// Bench for laser_frame_deserializer: frames are built bit by bit from bytes and the
// expected pulse cycles come from the frame timing (2-flop sync + 40-cycle frame).
module tb_laser_frame_deserializer;

  localparam int unsigned OS = 4;
  localparam int unsigned DB = 8;
  localparam int          FL = (DB + 2) * OS;  // pulse lands FL cycles after start bit
  localparam int          H  = OS / 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          en;
  logic          laser_in;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  laser_frame_deserializer #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .laser_in  (laser_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            at;
    bit            is_err;
    logic [DB-1:0] data;
  } ev_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  ev_t           evq[$];
  int            dv_cycles[$];
  logic [DB-1:0] model_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_dv, exp_fe;
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      if (evq[0].is_err) exp_fe = 1'b1;
      else begin
        exp_dv     = 1'b1;
        model_data = evq[0].data;
      end
      void'(evq.pop_front());
    end
    if (data_valid === 1'b1) dv_cycles.push_back(cyc);
    chk("data_valid", 32'(data_valid), 32'(exp_dv));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("data_out", 32'(data_out), 32'(model_data));
  endtask

  // Apply laser level for one cycle, then observe on the falling edge.
  task automatic step(input logic lvl);
    laser_in = lvl;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  // abort_kind: 0 none, 1 drop en at abort_off, 2 assert reset at abort_off.
  task automatic send_frame(input logic [DB-1:0] d, input int stop_len, input logic stop_lvl,
                            input int abort_kind, input int abort_off);
    int   s;
    int   total;
    logic lvl;
    s     = cyc + 1;
    total = OS * (DB + 1) + stop_len;
    if (abort_kind == 0) evq.push_back('{at: s + FL, is_err: stop_lvl, data: d});
    for (int off = 0; off < total; off++) begin
      if (off < OS) lvl = 1'b1;
      else if (off < OS * (DB + 1)) lvl = d[(off - OS) / OS];
      else lvl = stop_lvl;
      if (abort_kind == 1 && off == abort_off) begin
        chk("busy before en drop", 32'(busy), 32'd1);
        en = 1'b0;
      end
      if (abort_kind == 2 && off == abort_off) begin
        chk("busy before reset", 32'(busy), 32'd1);
        reset_n    = 1'b0;
        model_data = '0;
        #1;
        chk("async data_out", 32'(data_out), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async data_valid", 32'(data_valid), 32'd0);
      end
      step(lvl);
      if (abort_kind == 1 && off == abort_off) chk("busy after en drop", 32'(busy), 32'd0);
      if (abort_kind == 2 && off >= abort_off) chk("busy in reset", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int bc;
    logic [DB-1:0] rd;

    reset_n  = 1'b0;
    en       = 1'b1;
    laser_in = 1'b0;

    // Reset held for 3 cycles while the input toggles.
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b0 : 1'b1);
      chk("busy in reset", 32'(busy), 32'd0);
    end
    reset_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Back-to-back frames, no idle gap.
    dv_cycles.delete();
    send_frame(8'h12, OS, 1'b0, 0, 0);
    send_frame(8'h34, OS, 1'b0, 0, 0);
    step(1'b0);
    step(1'b0);
    chk("b2b pulse count", 32'(dv_cycles.size()), 32'd2);
    if (dv_cycles.size() == 2) chk("b2b spacing", 32'(dv_cycles[1] - dv_cycles[0]), 32'd40);

    // One-cycle glitch while idle.
    bc = 0;
    step(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (busy === 1'b1) bc++;
    end
    chk("glitch busy within H+1", 32'(bc >= 1 && bc <= H + 1), 32'd1);
    chk("glitch idle after", 32'(busy), 32'd0);

    // Bad stop bit held high for 12 cycles.
    send_frame(8'hA5, 12, 1'b1, 0, 0);
    chk("busy at end of stuck stop", 32'(busy), 32'd1);
    step(1'b0);
    chk("busy 1 after drop", 32'(busy), 32'd1);
    step(1'b0);
    chk("busy 2 after drop", 32'(busy), 32'd1);
    step(1'b0);
    chk("busy 3 after drop", 32'(busy), 32'd0);
    step(1'b0);

    // Enable dropped during data bit 4, then a clean frame.
    send_frame(8'hFF, OS, 1'b0, 1, OS + 4 * OS + 1);
    step(1'b0);
    en = 1'b1;
    step(1'b0);
    send_frame(8'h01, OS, 1'b0, 0, 0);
    step(1'b0);

    // Randomized frames with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      rd = DB'($urandom);
      send_frame(rd, OS, 1'b0, 0, 0);
      repeat ($urandom_range(0, 3)) step(1'b0);
    end
    step(1'b0);

    // Reset mid-frame at data bit 3, then a fresh frame.
    send_frame(8'hC3, OS, 1'b0, 2, OS + 3 * OS + 1);
    reset_n = 1'b1;
    step(1'b0);
    step(1'b0);
    send_frame(8'h5A, OS, 1'b0, 0, 0);
    step(1'b0);
    step(1'b0);
    chk("events drained", 32'(evq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
